// File: rtl/image_ram.sv
// -----------------------------------------------------------------------------
// image_ram
//   Single-port 2^ADDR_W x DATA_W synchronous RAM used as the data/image memory
//   of the image-processing processor. One bidirectional tri-state data bus is
//   shared with the datapath.
//
// Ports
//   clk            in     system clock, all state changes on the rising edge
//   rst_n          in     asynchronous active-low reset
//   address        in     word address, sampled on rising clk
//   data           inout  data bus: master drives on WRITE, RAM drives on READ
//   control_signal in     {ce, we, re}; we has priority over re
//
// Optional feature
//   RAM_INIT_CLEAR_EN : when defined, asserting rst_n clears every word to 0.
//                       When undefined, reset clears only the read register and
//                       the array contents are retained.
// -----------------------------------------------------------------------------
module image_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data,
  input  logic [2:0]        control_signal
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] rd_d;

  logic ce;
  logic we;
  logic re;
  logic wr_en;
  logic rd_en;
  logic drv_en;

  assign ce = control_signal[2];
  assign we = control_signal[1];
  assign re = control_signal[0];

  // Command decode; we wins over re so a write and a read never share a cycle.
  always_comb begin
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    drv_en = 1'b0;
    if (ce && we) begin
      wr_en = 1'b1;
    end else if (ce && re) begin
      rd_en = 1'b1;
    end
    // Bus ownership follows the live command, and reset always releases it.
    drv_en = rst_n && ce && re && !we;
  end

  always_comb begin
    rd_d = rd_q;
    if (rd_en) begin
      rd_d = mem_q[address];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  // The array only sees the reset branch when the clear feature is built in;
  // otherwise an edge taken during reset simply performs no write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef RAM_INIT_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
`else
      ;
`endif
    end else if (wr_en) begin
      mem_q[address] <= data;
    end
  end

  assign data = drv_en ? rd_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_image_ram.sv
// -----------------------------------------------------------------------------
// tb_image_ram
//   Self-checking bench for image_ram. A pullup on the data bus makes a released
//   bus read as all ones, so "RAM not driving" is observed as 16'hFFFF.
// -----------------------------------------------------------------------------
module tb_image_ram;

  localparam logic [15:0] PULL = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  addr;
  logic [2:0]  ctrl;
  logic        tb_drv;
  logic [15:0] tb_wdata;
  wire  [15:0] data;

  int checks = 0;
  int failures = 0;

  // Reference model: plain array of words plus a "has been written" flag.
  logic [15:0] ref_mem [256];
  bit          known   [256];

  assign data = tb_drv ? tb_wdata : 16'hzzzz;
  pullup (data);

  image_ram #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .address        (addr),
    .data           (data),
    .control_signal (ctrl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  c;
    logic [7:0]  a;
    logic [15:0] w;
    logic        drv;
    logic        chk;
    logic [15:0] exp;
  } vec_t;

  vec_t vt [14];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one command for one clock edge, then sample 1 time unit later.
  // The model is updated with what the spec says the edge does.
  task automatic apply(input logic [2:0] c, input logic [7:0] a,
                       input logic [15:0] w, input logic drv);
    @(negedge clk);
    ctrl     = c;
    addr     = a;
    tb_wdata = w;
    tb_drv   = drv;
    @(posedge clk);
    #1;
    if (rst_n && c[2] && c[1]) begin
      ref_mem[a] = drv ? w : PULL;
      known[a]   = 1'b1;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      known[i]   = 1'b0;
    end

    vt[0]  = '{3'b110, 8'h01, 16'h00C0, 1'b1, 1'b0, 16'h0000};
    vt[1]  = '{3'b101, 8'h01, 16'h0000, 1'b0, 1'b1, 16'h00C0};
    vt[2]  = '{3'b110, 8'h00, 16'hAAAA, 1'b1, 1'b0, 16'h0000};
    vt[3]  = '{3'b110, 8'hFF, 16'h5555, 1'b1, 1'b0, 16'h0000};
    vt[4]  = '{3'b101, 8'h00, 16'h0000, 1'b0, 1'b1, 16'hAAAA};
    vt[5]  = '{3'b101, 8'hFF, 16'h0000, 1'b0, 1'b1, 16'h5555};
    vt[6]  = '{3'b111, 8'h10, 16'h1234, 1'b1, 1'b0, 16'h0000};
    vt[7]  = '{3'b101, 8'h10, 16'h0000, 1'b0, 1'b1, 16'h1234};
    vt[8]  = '{3'b011, 8'h10, 16'hFFFF, 1'b1, 1'b0, 16'h0000};
    vt[9]  = '{3'b101, 8'h10, 16'h0000, 1'b0, 1'b1, 16'h1234};
    vt[10] = '{3'b100, 8'h10, 16'h0000, 1'b0, 1'b1, PULL};
    vt[11] = '{3'b001, 8'h10, 16'h0000, 1'b0, 1'b1, PULL};
    vt[12] = '{3'b111, 8'h31, 16'h0000, 1'b0, 1'b1, PULL};
    vt[13] = '{3'b101, 8'h00, 16'h0000, 1'b0, 1'b1, 16'hAAAA};

    // Reset then idle
    rst_n    = 1'b0;
    ctrl     = 3'b000;
    addr     = '0;
    tb_drv   = 1'b0;
    tb_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_bus_z", data, PULL);
    check("reset_rd_reg", dut.rd_q, 16'h0000);
    ctrl = 3'b101;
    #1;
    check("reset_read_gated", data, PULL);
    @(negedge clk);
    ctrl  = 3'b000;
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      apply(vt[i].c, vt[i].a, vt[i].w, vt[i].drv);
      if (vt[i].chk) check($sformatf("vec%0d", i), data, vt[i].exp);
    end

    // Bus release mid-cycle: read, then drop the command between edges
    apply(3'b101, 8'h01, 16'h0000, 1'b0);
    check("release_pre", data, 16'h00C0);
    #1 ctrl = 3'b000;
    #1 check("release_idle", data, PULL);
    ctrl = 3'b101;
    #1 check("release_redrive", data, 16'h00C0);
    ctrl = 3'b110;
    #0.5 check("release_to_write", data, PULL);
    ctrl = 3'b000;

    // Reset mid-operation while reading 0x20
    apply(3'b110, 8'h20, 16'hBEEF, 1'b1);
    apply(3'b101, 8'h20, 16'h0000, 1'b0);
    check("pre_reset_read", data, 16'hBEEF);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_bus_z", data, PULL);
    check("midreset_rd_reg", dut.rd_q, 16'h0000);
    #1 rst_n = 1'b1;
`ifdef RAM_INIT_CLEAR_EN
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      known[i]   = 1'b1;
    end
`endif
    @(posedge clk);
    #1;
    check("post_reset_read", data, ref_mem[8'h20]);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      logic [2:0]  c;
      logic [7:0]  a;
      logic [15:0] w;
      logic [15:0] exp;
      bit          rd;
      c   = 3'($urandom_range(0, 7));
      a   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      w   = 16'($urandom);
      rd  = c[2] && !c[1] && c[0];
      exp = ref_mem[a];
      if (rd && known[a]) begin
        apply(c, a, w, c[1]);
        check("rand_read", data, exp);
      end else if (!rd && !c[1]) begin
        apply(c, a, w, c[1]);
        check("rand_release", data, PULL);
      end else begin
        apply(c, a, w, c[1]);
      end
    end

    @(negedge clk);
    ctrl   = 3'b000;
    tb_drv = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/image_ram.md
Name: image_ram

Overview:
- Single-port 256 x 16-bit synchronous RAM.
- Serves as the data/image memory of the custom image-processing processor.
- Has one bidirectional tri-state data bus shared with the datapath.
- A 3-bit control word from the control unit selects write, read or idle.

Parameters:
- ADDR_W, 8, address width; depth = 2^ADDR_W words (256).
- DATA_W, 16, word width in bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- address  input  ADDR_W  word address, sampled on rising clk.
- data  inout  DATA_W  bidirectional data bus. The external master drives it during writes; the RAM drives it during reads; otherwise high-Z.
- control_signal  input  3  bit2 = chip enable (ce), bit1 = write enable (we), bit0 = read enable (re).

Behaviour:
- Command decode, evaluated each rising clk:
  - ce=0: idle.
  - ce=1, we=1: WRITE. we has priority over re.
  - ce=1, we=0, re=1: READ.
  - ce=1, we=0, re=0: idle.
- WRITE:
  - mem[address] <= data at the rising edge.
  - RAM keeps data high-Z throughout, so the master can drive it.
  - The write is visible to a READ on the next cycle.
- READ:
  - rd_reg <= mem[address] at the rising edge.
  - Latency 1 clk: value is valid on data after the edge where READ is sampled.
- Bus drive:
  - data = rd_reg while (ce & re & ~we) is currently asserted; else high-Z.
  - Drive enable is combinational from control_signal, so the RAM releases the bus the same cycle a READ command is removed or changed to WRITE.
- Mem contents are held while idle, including when ce=0.
- Read-during-write: a WRITE and a READ cannot occur in the same cycle because we has priority. A READ to an address written the previous cycle returns the new data.
- Address boundaries:
  - Full 8-bit range 0x00..0xFF valid; no wrap or aliasing.
  - With ADDR_W < 8, the upper address bits are ignored.
- Reset (rst_n=0, asynchronous):
  - rd_reg cleared to 0; data bus high-Z.
  - Any write in progress is aborted; the addressed word keeps its old value.
  - Mem contents are unaffected unless RAM_INIT_CLEAR_EN is defined.
  - Release is synchronous to the next rising clk; the first command is accepted on the first edge with rst_n=1.
- Control_signal X/Z is treated as idle for writes: no write occurs unless we is 1.

Optional Feature:
- Macro: RAM_INIT_CLEAR_EN.
- Defined: assertion of rst_n=0 asynchronously clears all 2^ADDR_W words to 0, in addition to clearing rd_reg.
- Undefined: reset clears only rd_reg; mem contents are retained across reset (power-up contents X).

Test Plan:
- Reset then idle: rst_n=0 for 2 clk, control=3'b000 -> data is Z, rd_reg=0.
- Write then read:
  - Stimulus: address=0x01; control=3'b110 with data=0x00C0 for 1 clk; then control=3'b101.
  - Response: one clk after the read is sampled, data=0x00C0; RAM never drives during the write cycle.
- Boundary addresses: write 0xAAAA to 0x00 and 0x5555 to 0xFF, read both -> 0xAAAA and 0x5555 respectively, no aliasing.
- Priority and disable:
  - control=3'b111, data=0x1234 at address 0x10 -> write occurs and the RAM does not drive; a later read returns 0x1234.
  - control=3'b011 (ce=0), data=0xFFFF at 0x10 -> no write; a read still returns 0x1234.
- Bus release: read active, then control=3'b000 mid-cycle -> data goes Z combinationally in the same cycle.
- Reset mid-operation:
  - Stimulus: 0xBEEF stored at 0x20; then rst_n pulsed low asynchronously between edges while reading 0x20.
  - Response: data goes Z at once and rd_reg=0. After release, a read of 0x20 returns 0xBEEF with the macro undefined, or 0x0000 with RAM_INIT_CLEAR_EN defined.
